// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port identifiers and
// default geometry / lock-length values.
package dmem_arbiter_pkg;

  // Port identifiers, also used as the one-bit pointer / owner encoding.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Default memory geometry and lock length.
  localparam int ADDR_W_DEF   = 10;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_LOCK_DEF = 4;

  // Lock counter width; MAX_LOCK is limited to 1..15.
  localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector with a lock override.
// The grant is one-hot: bit 0 = port A, bit 1 = port B.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       last_i,
  input  logic       lock_owner_i,
  input  logic       lock_active_i,
  output logic [1:0] gnt_o
);

  logic winner_s;

  // Pick the winner: a lone requester always wins; under contention the lock
  // owner wins if a lock is held, otherwise the port not granted last time.
  always_comb begin
    gnt_o    = 2'b00;
    winner_s = PORT_A;
    if (req_a_i && req_b_i) begin
      if (lock_active_i) begin
        winner_s = lock_owner_i;
      end else begin
        winner_s = ~last_i;
      end
      gnt_o = (winner_s == PORT_A) ? 2'b01 : 2'b10;
    end else if (req_a_i) begin
      gnt_o = 2'b01;
    end else if (req_b_i) begin
      gnt_o = 2'b10;
    end else begin
      gnt_o = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port synchronous data memory between port A
// (CPU) and port B (debug/DMA). Grants one access per cycle, drives the
// memory command, and routes read data back one cycle later to its owner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              A_Req,
  input  logic              A_Write,
  input  logic              A_Lock,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_WData,
  output logic              A_Gnt,
  output logic              A_RValid,
  output logic [DATA_W-1:0] A_RData,
  input  logic              B_Req,
  input  logic              B_Write,
  input  logic              B_Lock,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_WData,
  output logic              B_Gnt,
  output logic              B_RValid,
  output logic [DATA_W-1:0] B_RData,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  output logic              Mem_MemRead,
  output logic              Mem_MemWrite,
  input  logic [DATA_W-1:0] Mem_ReadData
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  // Last-grant pointer doubles as the registered command-mux select.
  logic                  last_q, last_d;
  logic                  lock_active_q, lock_active_d;
  logic                  lock_owner_q, lock_owner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  rv_q, rv_d;
  logic                  tag_q, tag_d;

  logic [1:0]            gnt_s;
  logic                  any_gnt_s;
  logic                  sel_s;
  logic                  sel_write_s;
  logic                  sel_lock_s;
  logic [LOCK_CNT_W-1:0] cnt_inc_s;
  logic                  a_rv_s;
  logic                  b_rv_s;

  rr_pick2 u_pick (
    .req_a_i       (A_Req),
    .req_b_i       (B_Req),
    .last_i        (last_q),
    .lock_owner_i  (lock_owner_q),
    .lock_active_i (lock_active_q),
    .gnt_o         (gnt_s)
  );

  // With no grant the mux stays on the last granted port.
  assign any_gnt_s   = gnt_s[0] | gnt_s[1];
  assign sel_s       = any_gnt_s ? gnt_s[1] : last_q;
  assign sel_write_s = (sel_s == PORT_B) ? B_Write : A_Write;
  assign sel_lock_s  = (sel_s == PORT_B) ? B_Lock  : A_Lock;

  // Memory command; strobes and grants are held low while in reset.
  assign Mem_Address   = (sel_s == PORT_B) ? B_Addr  : A_Addr;
  assign Mem_WriteData = (sel_s == PORT_B) ? B_WData : A_WData;
  assign Mem_MemRead   = Reset_n & any_gnt_s & ~sel_write_s;
  assign Mem_MemWrite  = Reset_n & any_gnt_s &  sel_write_s;
  assign A_Gnt         = Reset_n & gnt_s[0];
  assign B_Gnt         = Reset_n & gnt_s[1];

  // Read return: the tagged owner sees memory data, the other side sees zero.
  assign a_rv_s   = Reset_n & rv_q & (tag_q == PORT_A);
  assign b_rv_s   = Reset_n & rv_q & (tag_q == PORT_B);
  assign A_RValid = a_rv_s;
  assign B_RValid = b_rv_s;
  assign A_RData  = a_rv_s ? Mem_ReadData : {DATA_W{1'b0}};
  assign B_RData  = b_rv_s ? Mem_ReadData : {DATA_W{1'b0}};

  // Next state: pointer follows the grant, reads arm the response tag, and a
  // locked grant extends or starts the lock until it hits MAX_LOCK.
  always_comb begin
    last_d        = last_q;
    lock_active_d = 1'b0;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = {LOCK_CNT_W{1'b0}};
    rv_d          = 1'b0;
    tag_d         = tag_q;
    cnt_inc_s     = {LOCK_CNT_W{1'b0}};
    if (any_gnt_s) begin
      last_d = sel_s;
      rv_d   = ~sel_write_s;
      tag_d  = sel_s;
      if (sel_lock_s) begin
        if (lock_active_q && (lock_owner_q == sel_s)) begin
          cnt_inc_s = lock_cnt_q + {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_inc_s = {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
        end
        if (cnt_inc_s >= MAX_LOCK_C) begin
          lock_active_d = 1'b0;
          lock_cnt_d    = {LOCK_CNT_W{1'b0}};
        end else begin
          lock_active_d = 1'b1;
          lock_owner_d  = sel_s;
          lock_cnt_d    = cnt_inc_s;
        end
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = {LOCK_CNT_W{1'b0}};
      end
    end else begin
      lock_active_d = 1'b0;
      lock_cnt_d    = {LOCK_CNT_W{1'b0}};
    end
  end

  // State registers; reset points at B so A wins the first contention.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q        <= PORT_B;
      lock_active_q <= 1'b0;
      lock_owner_q  <= PORT_A;
      lock_cnt_q    <= {LOCK_CNT_W{1'b0}};
      rv_q          <= 1'b0;
      tag_q         <= PORT_A;
    end else begin
      last_q        <= last_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      rv_q          <= rv_d;
      tag_q         <= tag_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a directed vector table for the main scenarios,
// a hand-written reset-during-read sequence, then random traffic compared
// against a behavioural model of the arbitration and memory.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int ML = 4;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          A_Req, A_Write, A_Lock, B_Req, B_Write, B_Lock;
  logic [AW-1:0] A_Addr, B_Addr, Mem_Address;
  logic [DW-1:0] A_WData, B_WData, A_RData, B_RData, Mem_WriteData, Mem_ReadData;
  logic          A_Gnt, B_Gnt, A_RValid, B_RValid, Mem_MemRead, Mem_MemWrite;

  always #5 Clock = ~Clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .A_Req(A_Req), .A_Write(A_Write), .A_Lock(A_Lock), .A_Addr(A_Addr),
    .A_WData(A_WData), .A_Gnt(A_Gnt), .A_RValid(A_RValid), .A_RData(A_RData),
    .B_Req(B_Req), .B_Write(B_Write), .B_Lock(B_Lock), .B_Addr(B_Addr),
    .B_WData(B_WData), .B_Gnt(B_Gnt), .B_RValid(B_RValid), .B_RData(B_RData),
    .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
    .Mem_MemRead(Mem_MemRead), .Mem_MemWrite(Mem_MemWrite),
    .Mem_ReadData(Mem_ReadData)
  );

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous 1024x32 memory; reloaded with a known pattern while in reset.
  logic [DW-1:0] mem [1024];
  always @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (Mem_MemWrite) mem[Mem_Address] <= Mem_WriteData;
      if (Mem_MemRead) Mem_ReadData <= mem[Mem_Address];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  int            m_last;    // port granted most recently (0 = A, 1 = B)
  int            m_owner;   // port holding the lock
  int            m_streak;  // consecutive locked grants; 0 = no lock
  bit            m_pv;      // read response due next cycle
  int            m_pp;
  logic [31:0]   m_pd;
  logic [31:0]   ref_mem [1024];

  task automatic m_reset();
    m_last = 1; m_owner = 0; m_streak = 0; m_pv = 1'b0; m_pp = 0; m_pd = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
  endtask

  function automatic int m_grant();
    if (A_Req && B_Req) return (m_streak > 0) ? m_owner : 1 - m_last;
    else if (A_Req) return 0;
    else if (B_Req) return 1;
    else return -1;
  endfunction

  task automatic m_commit(input int g);
    logic          wr, lk;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    if (g < 0) begin
      m_pv = 1'b0; m_streak = 0;
    end else begin
      wr = (g == 1) ? B_Write : A_Write;
      lk = (g == 1) ? B_Lock  : A_Lock;
      ad = (g == 1) ? B_Addr  : A_Addr;
      wd = (g == 1) ? B_WData : A_WData;
      if (wr) begin
        ref_mem[ad] = wd; m_pv = 1'b0;
      end else begin
        m_pv = 1'b1; m_pp = g; m_pd = ref_mem[ad];
      end
      if (lk) begin
        m_streak = (m_streak > 0 && m_owner == g) ? m_streak + 1 : 1;
        m_owner = g;
        if (m_streak >= ML) m_streak = 0;
      end else begin
        m_streak = 0;
      end
      m_last = g;
    end
  endtask

  task automatic cmp_out(input string t, input logic eag, input logic ebg,
                         input logic earv, input logic ebrv,
                         input logic [31:0] eard, input logic [31:0] ebrd,
                         input logic emr, input logic emw, input logic [AW-1:0] eaddr);
    chk({t, " A_Gnt"}, 32'(A_Gnt), 32'(eag));
    chk({t, " B_Gnt"}, 32'(B_Gnt), 32'(ebg));
    chk({t, " A_RValid"}, 32'(A_RValid), 32'(earv));
    chk({t, " B_RValid"}, 32'(B_RValid), 32'(ebrv));
    chk({t, " A_RData"}, A_RData, eard);
    chk({t, " B_RData"}, B_RData, ebrd);
    chk({t, " MemRead"}, 32'(Mem_MemRead), 32'(emr));
    chk({t, " MemWrite"}, 32'(Mem_MemWrite), 32'(emw));
    if (eag || ebg) chk({t, " Mem_Address"}, 32'(Mem_Address), 32'(eaddr));
  endtask

  task automatic drive(input logic ar, input logic aw, input logic al, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic br, input logic bw, input logic bl,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    A_Req = ar; A_Write = aw; A_Lock = al; A_Addr = aa; A_WData = ad;
    B_Req = br; B_Write = bw; B_Lock = bl; B_Addr = ba; B_WData = bd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ar, aw, al; logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic br, bw, bl; logic [AW-1:0] ba; logic [DW-1:0] bd;
    logic eag, ebg, earv, ebrv; logic [DW-1:0] eard, ebrd;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic al, input int aa,
                              input logic [31:0] ad, input logic br, input logic bw,
                              input logic bl, input int ba, input logic [31:0] bd,
                              input logic eag, input logic ebg, input logic earv,
                              input logic ebrv, input logic [31:0] eard, input logic [31:0] ebrd);
    vec_t v;
    v.ar = ar; v.aw = aw; v.al = al; v.aa = AW'(aa); v.ad = ad;
    v.br = br; v.bw = bw; v.bl = bl; v.ba = AW'(ba); v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.earv = earv; v.ebrv = ebrv; v.eard = eard; v.ebrd = ebrd;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t tbl [NV];

  bit a_hold, b_hold;

  initial begin
    logic [31:0] DB;
    logic [31:0] RW;
    logic [31:0] Z;
    int g;
    logic [AW-1:0] ra;
    DB = 32'hDEAD_BEEF; RW = 32'h1234_5678; Z = 32'h0;

    // Reset with both ports requesting: nothing may be granted or strobed.
    m_reset();
    Reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 10'd0, Z, 1'b1, 1'b0, 1'b0, 10'd0, Z);
    repeat (3) @(posedge Clock);
    @(negedge Clock); #1;
    cmp_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 10'd0);

    //            ar  aw  al  aa    ad  br  bw  bl  ba     bd   eag ebg arv brv ard  brd
    tbl[0]  = mk(1, 1, 0, 5,    DB, 1, 0, 0, 7,     Z,  1, 0, 0, 0, Z,  Z);
    tbl[1]  = mk(1, 0, 0, 5,    Z,  1, 0, 0, 7,     Z,  0, 1, 0, 0, Z,  Z);
    tbl[2]  = mk(1, 0, 0, 5,    Z,  0, 0, 0, 0,     Z,  1, 0, 0, 1, Z,  init_val(7));
    tbl[3]  = mk(0, 0, 0, 0,    Z,  0, 0, 0, 0,     Z,  0, 0, 1, 0, DB, Z);
    tbl[4]  = mk(1, 0, 0, 5,    Z,  1, 0, 0, 5,     Z,  0, 1, 0, 0, Z,  Z);
    tbl[5]  = mk(1, 0, 0, 5,    Z,  1, 0, 0, 5,     Z,  1, 0, 0, 1, Z,  DB);
    tbl[6]  = mk(1, 0, 0, 5,    Z,  1, 0, 0, 5,     Z,  0, 1, 1, 0, DB, Z);
    tbl[7]  = mk(1, 0, 0, 5,    Z,  1, 0, 0, 5,     Z,  1, 0, 0, 1, Z,  DB);
    tbl[8]  = mk(0, 0, 0, 0,    Z,  0, 0, 0, 0,     Z,  0, 0, 1, 0, DB, Z);
    tbl[9]  = mk(1, 0, 1, 5,    Z,  0, 0, 0, 0,     Z,  1, 0, 0, 0, Z,  Z);
    tbl[10] = mk(1, 0, 1, 5,    Z,  1, 0, 0, 5,     Z,  1, 0, 1, 0, DB, Z);
    tbl[11] = mk(1, 0, 1, 5,    Z,  1, 0, 0, 5,     Z,  1, 0, 1, 0, DB, Z);
    tbl[12] = mk(1, 0, 1, 5,    Z,  1, 0, 0, 5,     Z,  1, 0, 1, 0, DB, Z);
    tbl[13] = mk(1, 0, 1, 5,    Z,  1, 0, 0, 5,     Z,  0, 1, 1, 0, DB, Z);
    tbl[14] = mk(1, 0, 0, 5,    Z,  1, 0, 0, 5,     Z,  1, 0, 0, 1, Z,  DB);
    tbl[15] = mk(1, 0, 0, 5,    Z,  1, 0, 0, 5,     Z,  0, 1, 1, 0, DB, Z);
    tbl[16] = mk(0, 0, 0, 0,    Z,  1, 1, 0, 1023,  RW, 0, 1, 0, 1, Z,  DB);
    tbl[17] = mk(1, 0, 0, 1023, Z,  0, 0, 0, 0,     Z,  1, 0, 0, 0, Z,  Z);
    tbl[18] = mk(0, 0, 0, 0,    Z,  0, 0, 0, 0,     Z,  0, 0, 1, 0, RW, Z);

    Reset_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ar, tbl[i].aw, tbl[i].al, tbl[i].aa, tbl[i].ad,
            tbl[i].br, tbl[i].bw, tbl[i].bl, tbl[i].ba, tbl[i].bd);
      #1;
      g = m_grant();
      cmp_out($sformatf("vec%0d", i), tbl[i].eag, tbl[i].ebg, tbl[i].earv, tbl[i].ebrv,
              tbl[i].eard, tbl[i].ebrd,
              (tbl[i].eag & ~tbl[i].aw) | (tbl[i].ebg & ~tbl[i].bw),
              (tbl[i].eag & tbl[i].aw) | (tbl[i].ebg & tbl[i].bw),
              tbl[i].eag ? tbl[i].aa : tbl[i].ba);
      @(posedge Clock);
      m_commit(g);
      @(negedge Clock);
    end

    // Reset arriving while an A read response is due drops that response.
    drive(1'b1, 1'b0, 1'b0, 10'd5, Z, 1'b0, 1'b0, 1'b0, 10'd0, Z);
    #1;
    chk("midrst grant", 32'(A_Gnt), 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    drive(1'b0, 1'b0, 1'b0, 10'd0, Z, 1'b0, 1'b0, 1'b0, 10'd0, Z);
    #1;
    chk("midrst pre rvalid", 32'(A_RValid), 32'd1);
    chk("midrst pre rdata", A_RData, DB);
    Reset_n = 1'b0;
    #1;
    chk("midrst rvalid in reset", 32'(A_RValid), 32'd0);
    chk("midrst rdata in reset", A_RData, Z);
    m_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    chk("midrst rvalid after", 32'(A_RValid), 32'd0);
    @(posedge Clock);
    @(negedge Clock); #1;
    chk("midrst rvalid later", 32'(A_RValid), 32'd0);
    @(negedge Clock);

    // Random traffic against the model; a request is held until granted.
    a_hold = 1'b0; b_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_hold) begin
        ra = ($urandom_range(0, 8) == 8) ? 10'd1023 : AW'($urandom_range(0, 7));
        A_Req = ($urandom_range(0, 3) != 0); A_Write = 1'($urandom_range(0, 1));
        A_Lock = ($urandom_range(0, 2) == 0); A_Addr = ra; A_WData = $urandom;
      end
      if (!b_hold) begin
        ra = ($urandom_range(0, 8) == 8) ? 10'd1023 : AW'($urandom_range(0, 7));
        B_Req = ($urandom_range(0, 3) != 0); B_Write = 1'($urandom_range(0, 1));
        B_Lock = ($urandom_range(0, 2) == 0); B_Addr = ra; B_WData = $urandom;
      end
      #1;
      g = m_grant();
      cmp_out("rnd", g == 0, g == 1, m_pv && m_pp == 0, m_pv && m_pp == 1,
              (m_pv && m_pp == 0) ? m_pd : Z, (m_pv && m_pp == 1) ? m_pd : Z,
              (g == 0 && !A_Write) || (g == 1 && !B_Write),
              (g == 0 && A_Write) || (g == 1 && B_Write),
              (g == 1) ? B_Addr : A_Addr);
      @(posedge Clock);
      m_commit(g);
      a_hold = A_Req && (g != 0);
      b_hold = B_Req && (g != 1);
      @(negedge Clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, 1024x32 synchronous data memory between two requesters: port A (CPU load/store stage) and port B (debug/DMA loader).
- Grants one access per cycle and drives the memory command: Address, WriteData, MemRead, MemWrite.
- The memory returns read data one cycle after the command. The arbiter routes that data back to the requester that issued the read.
- Arbitration is round-robin, with an optional bounded lock for atomic read-modify-write sequences.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
MAX_LOCK, 4, maximum consecutive grants to one locked requester before a forced handover (range 1..15)

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
A_Req  in  1  port A request; held with command stable until A_Gnt
A_Write  in  1  1 = write, 0 = read
A_Lock  in  1  request to keep the grant on the next cycle
A_Addr  in  ADDR_W  word address
A_WData  in  DATA_W  write data
A_Gnt  out  1  access accepted this cycle
A_RValid  out  1  read data valid for port A
A_RData  out  DATA_W  read data
B_Req, B_Write, B_Lock, B_Addr, B_WData, B_Gnt, B_RValid, B_RData  same as port A, for port B
Mem_Address  out  ADDR_W  to memory Address
Mem_WriteData  out  DATA_W  to memory WriteData
Mem_MemRead  out  1  to memory MemRead
Mem_MemWrite  out  1  to memory MemWrite
Mem_ReadData  in  DATA_W  from memory ReadData

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Last-grant pointer resets to B, so A wins the first contention.
  - Lock owner resets to none; lock counter resets to 0; RValid tag registers reset to 0.
  - While Reset_n is low, Gnt, RValid, Mem_MemRead and Mem_MemWrite are forced to 0.
  - Reset mid-read drops the pending RValid.
- Grant logic (combinational, same cycle):
  - If exactly one port requests, grant it.
  - If both request, grant the port opposite the last-grant pointer, unless a lock is active (see Lock).
  - The granted port's command is muxed onto Mem_*: Mem_MemRead = Req & ~Write; Mem_MemWrite = Req & Write.
  - With no grant, Mem_MemRead = Mem_MemWrite = 0. Mem_Address and Mem_WriteData then hold the last granted port's values (mux select is registered).
- Pointer update: at each rising edge with a grant, the last-grant pointer is set to the granted port.
- Read return:
  - Granted read in cycle N: the memory registers data at the N/N+1 edge.
  - In cycle N+1 the owner's RValid = 1 and its RData = Mem_ReadData.
  - A one-bit valid register plus a one-bit owner tag track this.
  - Back-to-back reads give one result per cycle.
  - The non-owner's RData is 0.
- Writes: complete at the grant edge; no response.
- Same-address read then write, or write then read, in consecutive cycles: memory order applies. A read granted the cycle after a write returns the new data.
- Lock:
  - Lock is set at an edge when the granted port has Lock = 1. While set, that owner wins contention.
  - The lock counter increments on each locked grant.
  - The lock is released when the owner deasserts Lock, does not request, or the counter reaches MAX_LOCK.
  - On a MAX_LOCK release, the other port wins the next contention. The counter clears on any release.
- Simultaneous lock requests: only the granted port's Lock is honoured.
- Protocol error: Req deasserted before Gnt is legal (withdrawn request) and needs no error handling.

Decomposition:
- Shared package constants: port IDs (PORT_A = 0, PORT_B = 1), default ADDR_W, DATA_W, MAX_LOCK.
- One natural sub-module: rr_pick2, a two-way round-robin selector with a lock override (inputs: two requests, last pointer, lock owner, lock-active; outputs: one-hot grant).
- Everything else is inline: the command mux, the response tag, and the lock counter.

Test Plan:
- Reset: hold Reset_n = 0 with A_Req = B_Req = 1 -> both Gnt = 0, Mem_MemRead = Mem_MemWrite = 0. After release, cycle 1 grants A.
- Single port: A writes 0xDEADBEEF to address 5, then reads address 5 the next cycle -> A_RValid one cycle after the read grant, A_RData = 0xDEADBEEF, B_RValid = 0.
- Contention: A and B read continuously -> grants alternate A, B, A, B. RValid tags match the owners with one-cycle latency. Throughput is one access per cycle.
- Lock: A holds A_Lock = 1 while B requests, MAX_LOCK = 4 -> A is granted 4 consecutive cycles, B is granted cycle 5, then alternation resumes.
- Read-after-write race: B writes 0x12345678 to address 0x3FF in cycle N, A reads 0x3FF in cycle N+1 -> A_RData = 0x12345678 in cycle N+2.
- Reset mid-read: assert Reset_n low in the cycle after a granted A read -> A_RValid = 0 immediately and stays 0 after release.
